// File: rtl/inc_pulse_bcd_display.sv
// N_DIGITS BCD increment counter with a time-multiplexed common-anode 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module inc_pulse_bcd_display #(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    IncPulse_in,
    input  logic                    Clear,
    output logic [4*N_DIGITS-1:0]   count_bcd,
    output logic                    wrap_pulse,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an
);

    localparam int unsigned CNT_W = 4 * N_DIGITS;
    localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Reset asserts asynchronously; release is delayed two edges to avoid metastability.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [CNT_W-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic             carry;
    logic [3:0]       digit;
    logic [3:0]       cur_digit;
    logic             blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic             hi_nonzero;
`endif

    // BCD ripple increment; a carry out of the top digit is the wrap.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        carry   = IncPulse_in;
        digit   = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            digit = count_q[4*k +: 4];
            if (carry) begin
                if (digit >= 4'd9) begin
                    count_d[4*k +: 4] = 4'd0;
                end else begin
                    count_d[4*k +: 4] = digit + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (Clear) begin
            count_d = '0;
        end else begin
            wrap_d = carry;
        end
    end

    // Free-running refresh divider and digit index.
    always_comb begin
        ref_d = (ref_q == REF_LAST) ? '0 : ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Select the lit digit and decide whether it is a blanked leading zero.
    always_comb begin
        cur_digit = 4'd0;
        blank     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        hi_nonzero = 1'b0;
`endif
        for (int k = 0; k < N_DIGITS; k++) begin
            if (IDX_W'(k) == idx_q) begin
                cur_digit = count_q[4*k +: 4];
            end
`ifdef LEADING_ZERO_BLANK_EN
            if ((IDX_W'(k) >= idx_q) && (count_q[4*k +: 4] != 4'd0)) begin
                hi_nonzero = 1'b1;
            end
`endif
        end
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx_q != '0) && !hi_nonzero;
`endif
        seg_d = blank ? SEG_BLANK : seg_decode(cur_digit);
        an_d  = ~(N_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '1;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign count_bcd  = count_q;
    assign wrap_pulse = wrap_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_inc_pulse_bcd_display.sv
// Directed bench for inc_pulse_bcd_display (N_DIGITS=4, REFRESH_DIV=4).
module tb_inc_pulse_bcd_display;

    localparam int unsigned N  = 4;
    localparam int unsigned RD = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          inc = 1'b0;
    logic          clr = 1'b0;
    logic [15:0]   count_bcd;
    logic          wrap_pulse;
    logic [6:0]    seg;
    logic [3:0]    an;

    int total = 0;
    int bad   = 0;

    inc_pulse_bcd_display #(.N_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .IncPulse_in (inc),
        .Clear       (clr),
        .count_bcd   (count_bcd),
        .wrap_pulse  (wrap_pulse),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inc;
        logic        clr;
        int          reps;
        logic [15:0] cnt;
        logic        wrap;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs for n cycles; returns at the falling edge after the last rising edge.
    task automatic run(input int n, input logic i, input logic c);
        for (int k = 0; k < n; k++) begin
            inc = i;
            clr = c;
            @(negedge clk);
        end
        inc = 1'b0;
        clr = 1'b0;
    endtask

    // Align to the first cycle of an=E following an=7, then check one full scan frame.
    task automatic scan_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [3:0] prev;
        logic       found;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        exp_an[0] = 4'hE; exp_an[1] = 4'hD; exp_an[2] = 4'hB; exp_an[3] = 4'h7;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            prev = an;
            @(negedge clk);
            if (prev == 4'h7 && an == 4'hE) found = 1'b1;
        end
        check({name, "_align"}, 32'(found), 32'd1);
        for (int c = 0; c < 16; c++) begin
            check(name, {an, 1'b0, seg}, {exp_an[c/4], 1'b0, exp_seg[c/4]});
            if (c != 15) @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1,  16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1,  16'h0001, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1,  16'h0001, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8,  16'h0009, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1,  16'h0010, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2,  16'h0012, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2,  16'h0012, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3,  16'h0015, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1,  16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 7,  16'h0007, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1,  16'h0000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 99, 16'h0099, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1,  16'h0100, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1,  16'h0000, 1'b0};

        // Reset state while held
        repeat (5) @(negedge clk);
        check("rst_count", 32'(count_bcd), 32'h0);
        check("rst_wrap",  32'(wrap_pulse), 32'h0);
        check("rst_seg",   32'(seg), 32'h7F);
        check("rst_an",    32'(an), 32'hF);

        // Release: two synchroniser edges, then the first active edge lights digit 0
        resetN = 1'b1;
        @(negedge clk);
        check("rel_an_e1", 32'(an), 32'hF);
        @(negedge clk);
        check("rel_an_e2", 32'(an), 32'hF);
        @(negedge clk);
        check("rel_an_e3", 32'(an), 32'hE);
        check("rel_seg_e3", 32'(seg), 32'h40);

        foreach (vecs[v]) begin
            run(vecs[v].reps, vecs[v].inc, vecs[v].clr);
            check($sformatf("vec%0d_count", v), 32'(count_bcd), 32'(vecs[v].cnt));
            check($sformatf("vec%0d_wrap", v),  32'(wrap_pulse), 32'(vecs[v].wrap));
        end

        // 12 single pulses then 3 consecutive high cycles
        for (int p = 1; p <= 12; p++) begin
            run(1, 1'b1, 1'b0);
            run(1, 1'b0, 1'b0);
            if (p == 9)  check("pulse9",  32'(count_bcd), 32'h0009);
            if (p == 10) check("pulse10", 32'(count_bcd), 32'h0010);
        end
        run(3, 1'b1, 1'b0);
        check("pulse15", 32'(count_bcd), 32'h0015);

        // Wrap from 9999
        run(1, 1'b0, 1'b1);
        run(9999, 1'b1, 1'b0);
        check("pre_wrap_count", 32'(count_bcd), 32'h9999);
        check("pre_wrap_flag",  32'(wrap_pulse), 32'h0);
        run(1, 1'b1, 1'b0);
        check("wrap_count", 32'(count_bcd), 32'h0000);
        check("wrap_flag",  32'(wrap_pulse), 32'h1);
        run(1, 1'b0, 1'b0);
        check("wrap_flag_drop", 32'(wrap_pulse), 32'h0);
        check("wrap_count_hold", 32'(count_bcd), 32'h0000);

        // Clear beats an increment that would otherwise wrap
        run(9999, 1'b1, 1'b0);
        check("pre_wrap2_count", 32'(count_bcd), 32'h9999);
        run(1, 1'b1, 1'b1);
        check("clr_wrap_count", 32'(count_bcd), 32'h0000);
        check("clr_wrap_flag",  32'(wrap_pulse), 32'h0);

        // Scan at 1234
        run(1234, 1'b1, 1'b0);
        check("cnt_1234", 32'(count_bcd), 32'h1234);
        scan_frame("scan1234", 7'h19, 7'h30, 7'h24, 7'h79);

        // Scan at 0042 (leading digits blank only when the macro is defined)
        run(1, 1'b0, 1'b1);
        run(42, 1'b1, 1'b0);
        check("cnt_0042", 32'(count_bcd), 32'h0042);
        scan_frame("scan0042", 7'h24, 7'h19, LZ_SEG, LZ_SEG);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async_count", 32'(count_bcd), 32'h0);
        check("async_wrap",  32'(wrap_pulse), 32'h0);
        check("async_seg",   32'(seg), 32'h7F);
        check("async_an",    32'(an), 32'hF);
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        check("rerel_an",  32'(an), 32'hE);
        check("rerel_seg", 32'(seg), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
